// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//   Generic pipeline stage register used between CPU stages. It moves a
//   control bundle and a data payload across a valid/ready handshake. It also
//   provides an optional skid entry, bubble insertion (control zeroed), a
//   synchronous flush and a saturating stall-cycle counter.
//
// Parameters
//   CTRL_W : control bundle width; zeroed by bubble and flush
//   DATA_W : payload width; cleared only by reset
//   SKID   : 1 = two entries, registered ready_o; 0 = one entry,
//            combinational ready_o
//   CNT_W  : stall counter width
//
// Ports
//   clk_i       in  : clock, every flop samples on the rising edge
//   rst_i       in  : asynchronous active-high reset
//   valid_i     in  : upstream beat valid
//   ready_o     out : stage can accept a beat
//   ctrl_i      in  : upstream control bundle
//   data_i      in  : upstream payload
//   noop_i      in  : capture the accepted beat with its control forced to 0
//   flush_i     in  : discard held and incoming beats
//   valid_o     out : output beat valid
//   ready_i     in  : downstream accepts
//   ctrl_o      out : registered control
//   data_o      out : registered payload
//   stall_cnt_o out : saturating count of cycles with valid_o=1, ready_i=0
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              noop_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              ready_s;
  logic              accept_s;
  logic              load_out_s;
  logic [CTRL_W-1:0] cin_s;
  logic              skid_valid_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [DATA_W-1:0] skid_data_s;

  // The output register can take a new beat when it is empty or draining.
  assign load_out_s = ~valid_r | ready_i;
  assign accept_s   = valid_i & ready_s & ~flush_i;

  // Captured control value: a bubble keeps the payload but zeroes the control.
  always_comb begin
    cin_s = {CTRL_W{1'b0}};
    if (noop_i) begin
      cin_s = {CTRL_W{1'b0}};
    end else begin
      cin_s = ctrl_i;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_valid_r;
      logic [CTRL_W-1:0] skid_ctrl_r;
      logic [DATA_W-1:0] skid_data_r;
      logic              skid_load_s;

      // A beat taken while the output is stalled parks in the skid entry.
      assign skid_load_s = accept_s & valid_r & ~ready_i;

      // Skid entry: fills on a stalled accept, empties into the output register.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          skid_valid_r <= 1'b0;
          skid_ctrl_r  <= {CTRL_W{1'b0}};
          skid_data_r  <= {DATA_W{1'b0}};
        end else if (flush_i) begin
          skid_valid_r <= 1'b0;
        end else if (skid_valid_r && load_out_s) begin
          skid_valid_r <= 1'b0;
        end else if (skid_load_s) begin
          skid_valid_r <= 1'b1;
          skid_ctrl_r  <= cin_s;
          skid_data_r  <= data_i;
        end else begin
          skid_valid_r <= skid_valid_r;
        end
      end

      assign skid_valid_s = skid_valid_r;
      assign skid_ctrl_s  = skid_ctrl_r;
      assign skid_data_s  = skid_data_r;
      // Registered ready: upstream sees back-pressure one cycle late, which
      // the skid entry absorbs.
      assign ready_s      = ~skid_valid_r;
    end else begin : g_noskid
      assign skid_valid_s = 1'b0;
      assign skid_ctrl_s  = {CTRL_W{1'b0}};
      assign skid_data_s  = {DATA_W{1'b0}};
      assign ready_s      = load_out_s;
    end
  endgenerate

  // Output register: flush wins, then the skid drains ahead of new input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
    end else if (flush_i) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
    end else if (load_out_s) begin
      if (skid_valid_s) begin
        valid_r <= 1'b1;
        ctrl_r  <= skid_ctrl_s;
        data_r  <= skid_data_s;
      end else if (accept_s) begin
        valid_r <= 1'b1;
        ctrl_r  <= cin_s;
        data_r  <= data_i;
      end else begin
        valid_r <= 1'b0;
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  // Stall counter: counts stalled output cycles, sticks at its maximum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (valid_r && !ready_i && !flush_i && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign ready_o     = ready_s;
  assign valid_o     = valid_r;
  assign ctrl_o      = ctrl_r;
  assign data_o      = data_r;
  assign stall_cnt_o = cnt_r;

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised pipeline stage register, the next generation of the ID/EX latch. It carries a configurable-width control bundle and data payload between two pipeline stages under a valid/ready handshake, and adds the following over the plain latch:
- optional skid buffer;
- bubble insertion (control zeroing);
- synchronous flush;
- asynchronous reset;
- saturating stall-cycle counter.

It is instantiated between every pair of CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- CTRL_W, 8, width of control bundle (RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc, ...); zeroed by bubble/flush
- DATA_W, 128, width of data payload (register data, rs/rd IDs, funct, imm); never zeroed except by reset
- SKID, 1, 1 = two-entry skid buffer (registered ready_o); 0 = single entry (combinational ready_o)
- CNT_W, 16, width of stall counter

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  upstream beat valid
- ready_o  out  1  stage can accept a beat
- ctrl_i  in  CTRL_W  upstream control bundle
- data_i  in  DATA_W  upstream payload
- noop_i  in  1  bubble: accepted beat captured with ctrl forced to 0
- flush_i  in  1  discard all held and incoming beats
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts
- ctrl_o  out  CTRL_W  registered control
- data_o  out  DATA_W  registered payload
- stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0, saturating

## Operation
Definitions:
- accept = valid_i & ready_o & ~flush_i
- ofire = valid_o & ready_i
- load_out = ~valid_o | ready_i

Captured control value: cin = noop_i ? 0 : ctrl_i. Data is always data_i.

Reset (async, while rst_i=1):
- valid_o=0, ctrl_o=0, data_o=0, stall_cnt_o=0
- skid valid=0, skid contents=0
- ready_o=1

Flush (flush_i=1, sync, highest priority):
- next valid_o=0, ctrl_o=0, skid valid=0
- data_o and skid data hold their values
- incoming beat dropped, ready_o ignored
- stall_cnt_o holds its value

Output register when load_out and not flush:
- if skid valid: output register ← skid entry, skid valid←0
- else if accept: ctrl_o←cin, data_o←data_i, valid_o←1
- else: valid_o←0, ctrl_o and data_o hold

Output register when ~load_out: all outputs hold. ctrl_o and data_o stay stable while valid_o=1 and ready_i=0.

Skid register (SKID=1 only):
- loads cin/data_i, skid valid←1, when accept & valid_o & ~ready_i
- ready_o = ~skid_valid (registered)
- at most one beat in the skid; a full skid blocks input

SKID=0:
- ready_o = ~valid_o | ready_i (combinational)
- no skid state

Stall counter:
- increments when valid_o & ~ready_i & ~flush_i
- saturates at 2^CNT_W−1
- never clears except on reset

Ordering:
- beats leave in acceptance order; none is duplicated or lost except by flush
- noop_i is sampled only on accept

## Timing
- Latency: a beat accepted at edge N appears on valid_o/ctrl_o/data_o after edge N (1 cycle).
- Throughput: 1 beat/cycle when ready_i=1, for both SKID values.
- SKID=1: ready_o falls the cycle after the skid fills, and rises the cycle after the skid drains into the output register.
- SKID=1: one extra beat is absorbed after downstream stalls, so upstream may compute valid from registered ready_o.
- Simultaneous accept and ofire with skid empty: output register takes the new beat, valid_o stays 1.
- Simultaneous flush and any other event: flush wins.
- The cycle after flush: ready_o=1.
- Reset asserted mid-stream: all held beats lost immediately (asynchronous), independent of clk_i.
- Reset deasserted: first accept is possible at the first rising edge with rst_i=0.

## Test plan
- Reset then stream: valid_i=1 for 4 cycles with ready_i=1, data 0x1..0x4, ctrl 0xA5 → valid_o high from cycle 1, data_o 0x1,0x2,0x3,0x4 on consecutive cycles, ctrl_o=0xA5, stall_cnt_o=0.
- Backpressure (SKID=1): stream 0x10,0x11,0x12 while ready_i=0 from cycle 1 → data_o holds 0x10, 0x11 lands in the skid, ready_o=0 from cycle 2, 0x12 held upstream; release ready_i → outputs 0x11 then 0x12, nothing lost; stall_cnt_o equals the number of stalled cycles.
- Bubble: noop_i=1 on beat 0x20 with ctrl 0xFF → ctrl_o=0x00, data_o=0x20, valid_o=1; the next beat without noop_i has ctrl_o=0xFF.
- Flush with skid full plus incoming beat → next cycle valid_o=0, ctrl_o=0, ready_o=1; no old beat ever reappears.
- Async reset pulse mid-cycle during a stall → valid_o, ctrl_o, data_o and stall_cnt_o are 0 before the next clock edge.
- Saturation: CNT_W=4, hold valid_o=1 and ready_i=0 for 20 cycles → stall_cnt_o stops at 15.
